// File: rtl/fifo_pkg.sv
// Shared definitions for blocks on the FIFO read side:
// read-sequencer state encoding and full-flag correction of the fill level.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;

    // A zero fill with a non-empty flag means the pointers wrapped: FIFO is full.
    function automatic logic [31:0] eff_fill_f(
        input logic [31:0] fill,
        input logic        empty,
        input int unsigned ptr_w
    );
        logic [31:0] res;
        res = fill;
        if (fill == 32'd0 && !empty) begin
            res = 32'd1 << ptr_w;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Read-domain burst consumer: pops fixed-length bursts (or a flushed tail)
// from a FWFT FIFO into a registered valid/ready stream with sob/eob markers.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned PTR_WIDTH  = 4,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_fifo_rd,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    input  logic                  i_fifo_empty,
    input  logic [PTR_WIDTH-1:0]  i_fifo_fill,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sob,
    output logic                  o_eob,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_burst_cnt
);

    localparam int unsigned FW = PTR_WIDTH + 1;
    localparam logic [FW-1:0] BLEN = FW'(BURST_LEN);

    rd_state_e             state_q, state_d;
    logic                  flush_q, flush_d;
    logic [FW-1:0]         left_q, left_d;
    logic [FW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sob_q, sob_d;
    logic                  eob_q, eob_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [FW-1:0] eff_fill;
    logic          slot_free;
    logic          pop;

    assign eff_fill  = FW'(eff_fill_f(32'(i_fifo_fill), i_fifo_empty, PTR_WIDTH));
    assign slot_free = !valid_q || i_ready;
    assign pop       = (state_q != ST_IDLE) && slot_free
                     && !i_fifo_empty && (left_q != '0);

    always_comb begin
        state_d = state_q;
        flush_d = flush_q || i_flush;
        left_d  = left_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        sob_d   = sob_q;
        eob_d   = eob_q;
        cnt_d   = cnt_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
            sob_d   = 1'b0;
            eob_d   = 1'b0;
        end

        if (pop) begin
            data_d  = i_fifo_rdata;
            valid_d = 1'b1;
            sob_d   = (idx_q == '0);
            eob_d   = (left_q == FW'(1));
            left_d  = left_q - FW'(1);
            idx_d   = idx_q + FW'(1);
            if (left_q == FW'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                // A full burst wins over a pending flush; the flush waits.
                if (eff_fill >= BLEN) begin
                    state_d = ST_BURST;
                    left_d  = BLEN;
                    idx_d   = '0;
                end else if (flush_q && eff_fill != '0) begin
                    state_d = ST_FLUSH;
                    left_d  = eff_fill;
                    idx_d   = '0;
                    flush_d = i_flush;
                end else if (flush_q) begin
                    flush_d = i_flush;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
            left_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sob_q   <= 1'b0;
            eob_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sob_q   <= sob_d;
            eob_q   <= eob_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_fifo_rd   = pop;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_sob       = sob_q;
    assign o_eob       = eob_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_burst_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO model, framing scoreboard,
// randomized data/ready/stalls and directed burst/flush/reset scenarios.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int BL = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          o_fifo_rd;
    logic [DW-1:0] i_fifo_rdata;
    logic          i_fifo_empty;
    logic [PW-1:0] i_fifo_fill;
    logic          i_flush;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_sob;
    logic          o_eob;
    logic          o_busy;
    logic [CW-1:0] o_burst_cnt;

    fifo_burst_reader #(
        .DATA_WIDTH(DW), .PTR_WIDTH(PW), .BURST_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .o_fifo_rd(o_fifo_rd),
        .i_fifo_rdata(i_fifo_rdata), .i_fifo_empty(i_fifo_empty),
        .i_fifo_fill(i_fifo_fill), .i_flush(i_flush),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_sob(o_sob), .o_eob(o_eob), .o_busy(o_busy),
        .o_burst_cnt(o_burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sob;
        logic          eob;
    } beat_t;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] wr_pend[$];
    logic [DW-1:0] src_q[$];
    beat_t         exp_q[$];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int rd_cnt = 0;
    int cyc_n = 0;
    int model_bursts = 0;
    int n_bursts = 0;
    int sob_cyc = 0;
    int eob_cyc = 0;
    int rdy_mode = 0;
    int rdy_phase = 0;
    logic mask_en = 1'b0;
    logic rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // FIFO model: pops follow the strobe seen before the edge; flags registered.
    always @(posedge clk) begin
        logic [DW-1:0] tmp;
        logic masked;
        #1;
        if (rd_seen && fq.size() > 0) tmp = fq.pop_front();
        while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
        rdy_phase++;
        case (rdy_mode)
            0: i_ready = 1'b1;
            1: i_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
        masked = mask_en && ($urandom_range(0, 2) == 0);
        if (fq.size() == 0 || masked) begin
            i_fifo_empty = 1'b1;
            i_fifo_fill  = '0;
            i_fifo_rdata = '0;
        end else begin
            i_fifo_empty = 1'b0;
            i_fifo_fill  = PW'(fq.size());
            i_fifo_rdata = fq[0];
        end
    end

    // Compare process: stream rules and scoreboard, checked mid-cycle.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_sob, prev_eob;
    beat_t         e;

    always @(negedge clk) begin
        cyc_n++;
        if (rst) begin
            rd_seen   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            rd_seen = o_fifo_rd;
            if (o_fifo_rd) begin
                rd_cnt++;
                chk("rd_while_empty", 32'(i_fifo_empty), 32'd0);
                chk("rd_slot_busy", 32'(!o_valid || i_ready), 32'd1);
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(prev_data));
                chk("hold_marks", {30'd0, o_sob, o_eob},
                    {30'd0, prev_sob, prev_eob});
            end
            if (o_valid && i_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none",
                             o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(o_data), 32'(e.d));
                    chk("beat_sob", 32'(o_sob), 32'(e.sob));
                    chk("beat_eob", 32'(o_eob), 32'(e.eob));
                    if (e.sob) sob_cyc = cyc_n;
                    if (e.eob) begin
                        model_bursts++;
                        eob_cyc = cyc_n;
                        chk("cnt_at_eob", 32'(o_burst_cnt), 32'(model_bursts));
                    end
                end
            end
            prev_hold = o_valid && !i_ready;
            prev_data = o_data;
            prev_sob  = o_sob;
            prev_eob  = o_eob;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        wr_pend.push_back(d);
        src_q.push_back(d);
    endtask

    task automatic wr(input int n);
        for (int i = 0; i < n; i++) wr_word(DW'($urandom));
    endtask

    task automatic frame(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d   = src_q.pop_front();
            b.sob = (i == 0);
            b.eob = (i == len - 1);
            exp_q.push_back(b);
        end
        n_bursts++;
    endtask

    task automatic flush_pulse();
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (i < 600 && !(exp_q.size() == 0 && !o_valid && !o_busy)) begin
            cyc();
            i++;
        end
        checks++;
        if (exp_q.size() != 0 || o_valid || o_busy) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required=0 beats left",
                     name, exp_q.size());
        end
        chk({name, "_cnt"}, 32'(o_burst_cnt), 32'(n_bursts));
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 400 && hs_cnt < target; i++) cyc();
        chk("wait_hs_reached", 32'(hs_cnt >= target), 32'd1);
    endtask

    initial begin
        int base, rd0, k;
        rst = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b1;
        i_fifo_empty = 1'b1;
        i_fifo_fill = '0;
        i_fifo_rdata = '0;
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cnt", 32'(o_burst_cnt), 32'd0);
        chk("rst_rd", 32'(o_fifo_rd), 32'd0);
        chk("rst_marks", {30'd0, o_sob, o_eob}, 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();
        chk("idle_valid", 32'(o_valid), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Eight ascending words at full throughput.
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) begin
            wr_word(DW'(i));
            cyc();
        end
        frame(8);
        drain("burst8");
        chk("burst8_cnt_lit", 32'(o_burst_cnt), 32'd1);
        chk("burst8_back2back", 32'(eob_cyc - sob_cyc), 32'd7);

        // Seven words sit untouched until a flush.
        rd0 = rd_cnt;
        wr(7);
        repeat (20) cyc();
        chk("partial_no_rd", 32'(rd_cnt - rd0), 32'd0);
        chk("partial_no_valid", 32'(o_valid), 32'd0);
        chk("partial_idle", 32'(o_busy), 32'd0);
        frame(7);
        flush_pulse();
        drain("flush7");
        chk("flush7_cnt_lit", 32'(o_burst_cnt), 32'd2);

        // Completely full FIFO: fill reads 0 while not empty.
        wr(16);
        frame(8);
        frame(8);
        drain("full16");
        chk("full16_cnt_lit", 32'(o_burst_cnt), 32'd4);

        // Ready pattern 1,0,0,1.
        rdy_mode = 1;
        wr(8);
        frame(8);
        drain("rdy_pat");

        // Random ready with transient empty stalls.
        rdy_mode = 2;
        mask_en = 1'b1;
        wr(8);
        frame(8);
        drain("stall");
        mask_en = 1'b0;

        // Flushed tail of 5; late words must not join it.
        base = hs_cnt;
        wr(5);
        cyc();
        frame(5);
        flush_pulse();
        wait_hs(base + 3);
        wr(3);
        drain("flush5");
        frame(3);
        flush_pulse();
        drain("flush3");

        // Flush during a burst is serviced after it.
        wr(11);
        frame(8);
        frame(3);
        for (int i = 0; i < 50 && !o_busy; i++) cyc();
        chk("burst_started", 32'(o_busy), 32'd1);
        flush_pulse();
        drain("burst_then_flush");
        chk("bf_cnt_lit", 32'(o_burst_cnt), 32'd10);

        // Random rounds.
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = int'($urandom_range(1, 7));
                wr(k);
                cyc();
                frame(k);
                flush_pulse();
            end else begin
                k = int'($urandom_range(1, 2));
                wr(8 * k);
                for (int j = 0; j < k; j++) frame(8);
            end
            drain("rand");
        end

        // Reset in the middle of a burst.
        rdy_mode = 0;
        base = hs_cnt;
        wr(8);
        frame(8);
        wait_hs(base + 4);
        rst = 1'b1;
        fq.delete();
        wr_pend.delete();
        src_q.delete();
        exp_q.delete();
        model_bursts = 0;
        n_bursts = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_cnt", 32'(o_burst_cnt), 32'd0);
        chk("midrst_rd", 32'(o_fifo_rd), 32'd0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();
        wr(8);
        frame(8);
        drain("recover");
        chk("recover_cnt_lit", 32'(o_burst_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
